// File: rtl/fetch_if_id_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the 16-bit datapath.
// Holds the PC, latches fetched words, and obeys stalls, branch flushes and the halt opcode.
module fetch_if_id_stage #(
    parameter int                  PC_WIDTH    = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter logic [15:0]         NOP_WORD    = 16'h0000,
    parameter logic [3:0]          HALT_OPCODE = 4'hF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                halt,
    input  logic                pc_enable,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic [15:0]         imem_data,
    output logic [PC_WIDTH-1:0] imem_addr,
    output logic [PC_WIDTH-1:0] pc_IF,
    output logic [15:0]         instruction_ID,
    output logic [PC_WIDTH-1:0] pc_plus2_ID,
    output logic                valid_ID,
    output logic                halted
);

    typedef enum logic [1:0] {FILL, RUN, HALTED} state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_d, pc_plus2_d, pc_inc;
    logic [15:0]         instr_d;
    logic                valid_d;

    assign pc_inc    = pc_IF + PC_WIDTH'(2);
    assign imem_addr = pc_IF;
    assign halted    = (state_q == HALTED);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_IF;
        pc_plus2_d = pc_plus2_ID;
        instr_d    = instruction_ID;
        valid_d    = valid_ID;
        // A branch redirects from any state, including FILL and HALTED.
        if (branch_taken) begin
            pc_d    = {branch_target[PC_WIDTH-1:1], 1'b0};
            instr_d = NOP_WORD;
            valid_d = 1'b0;
            state_d = RUN;
        end else begin
            case (state_q)
                FILL: state_d = RUN;
                RUN: begin
                    if (!halt) begin
                        instr_d    = imem_data;
                        pc_plus2_d = pc_inc;
                        valid_d    = 1'b1;
                        // The halt word is kept in ID while the PC freezes on it.
                        if (imem_data[15:12] == HALT_OPCODE)
                            state_d = HALTED;
                        else if (pc_enable)
                            pc_d = pc_inc;
                    end
                end
                HALTED: state_d = HALTED;
                default: state_d = FILL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= FILL;
            pc_IF          <= RESET_PC;
            instruction_ID <= NOP_WORD;
            pc_plus2_ID    <= '0;
            valid_ID       <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_IF          <= pc_d;
            instruction_ID <= instr_d;
            pc_plus2_ID    <= pc_plus2_d;
            valid_ID       <= valid_d;
        end
    end

endmodule

// File: tb/tb_fetch_if_id_stage.sv
// Table-driven bench for fetch_if_id_stage: each row drives one cycle and its
// expected outputs go through a scoreboard queue, checked #1 after the edge.
module tb_fetch_if_id_stage;

    logic        clk = 1'b0;
    logic        rst, halt, pc_enable, branch_taken;
    logic [15:0] branch_target, imem_data;
    logic [15:0] imem_addr, pc_IF, instruction_ID, pc_plus2_ID;
    logic        valid_ID, halted;

    fetch_if_id_stage dut (
        .clk           (clk),
        .rst           (rst),
        .halt          (halt),
        .pc_enable     (pc_enable),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_data     (imem_data),
        .imem_addr     (imem_addr),
        .pc_IF         (pc_IF),
        .instruction_ID(instruction_ID),
        .pc_plus2_ID   (pc_plus2_ID),
        .valid_ID      (valid_ID),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, halt, pe, br;
        logic [15:0] tgt, imem;
        logic [15:0] pc, instr, pp2;
        logic        v, h;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void add(input logic r, input logic hl, input logic pe, input logic br,
                                input logic [15:0] tgt, input logic [15:0] imem,
                                input logic [15:0] pc, input logic [15:0] instr,
                                input logic [15:0] pp2, input logic v, input logic h);
        vec_t t;
        t.rst = r; t.halt = hl; t.pe = pe; t.br = br; t.tgt = tgt; t.imem = imem;
        t.pc = pc; t.instr = instr; t.pp2 = pp2; t.v = v; t.h = h;
        vecs.push_back(t);
    endfunction

    task automatic check(input string name, input int row, input logic [15:0] act,
                         input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    initial begin
        //   rst hlt pe br  tgt       imem      pc        instr     pp2      v  h
        add(1, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0); // 0 reset
        add(0, 0, 1, 0, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 0, 0); // 1 FILL
        add(0, 0, 1, 0, 16'h0000, 16'h1234, 16'h0002, 16'h1234, 16'h0002, 1, 0); // 2
        add(0, 0, 1, 0, 16'h0000, 16'h2345, 16'h0004, 16'h2345, 16'h0004, 1, 0); // 3
        add(0, 0, 1, 0, 16'h0000, 16'ha43D, 16'h0006, 16'ha43D, 16'h0006, 1, 0); // 4
        add(0, 1, 0, 0, 16'h0000, 16'ha53D, 16'h0006, 16'ha43D, 16'h0006, 1, 0); // 5 stall
        add(0, 1, 0, 0, 16'h0000, 16'ha53D, 16'h0006, 16'ha43D, 16'h0006, 1, 0); // 6 stall
        add(0, 0, 1, 0, 16'h0000, 16'ha53D, 16'h0008, 16'ha53D, 16'h0008, 1, 0); // 7 release
        add(0, 0, 0, 0, 16'h0000, 16'h3333, 16'h0008, 16'h3333, 16'h000A, 1, 0); // 8 pc_enable=0
        add(0, 1, 1, 0, 16'h0000, 16'h4444, 16'h0008, 16'h3333, 16'h000A, 1, 0); // 9 stall, pe=1
        add(0, 1, 1, 0, 16'h0000, 16'hF123, 16'h0008, 16'h3333, 16'h000A, 1, 0); // 10 halt word in stall
        add(0, 1, 0, 1, 16'h0041, 16'h5555, 16'h0040, 16'h0000, 16'h000A, 0, 0); // 11 flush+halt
        add(0, 0, 1, 0, 16'h0000, 16'h6666, 16'h0042, 16'h6666, 16'h0042, 1, 0); // 12
        add(0, 0, 1, 1, 16'h0006, 16'h7777, 16'h0006, 16'h0000, 16'h0042, 0, 0); // 13 branch to 6
        add(0, 0, 1, 0, 16'h0000, 16'hF000, 16'h0006, 16'hF000, 16'h0008, 1, 1); // 14 halt opcode
        add(0, 0, 1, 0, 16'h0000, 16'h7777, 16'h0006, 16'hF000, 16'h0008, 1, 1); // 15 HALTED x5
        add(0, 1, 0, 0, 16'h0000, 16'h7777, 16'h0006, 16'hF000, 16'h0008, 1, 1);
        add(0, 0, 0, 0, 16'h0000, 16'h8888, 16'h0006, 16'hF000, 16'h0008, 1, 1);
        add(0, 1, 1, 0, 16'h0000, 16'h8888, 16'h0006, 16'hF000, 16'h0008, 1, 1);
        add(0, 0, 1, 0, 16'h0000, 16'hF000, 16'h0006, 16'hF000, 16'h0008, 1, 1);
        add(0, 0, 1, 1, 16'h0010, 16'hF000, 16'h0010, 16'h0000, 16'h0008, 0, 0); // 20 branch out
        add(0, 0, 1, 1, 16'hFFFF, 16'h0000, 16'hFFFE, 16'h0000, 16'h0008, 0, 0); // 21 bit0 dropped
        add(0, 0, 1, 0, 16'h0000, 16'h1111, 16'h0000, 16'h1111, 16'h0000, 1, 0); // 22 wrap
        add(0, 0, 1, 0, 16'h0000, 16'h2222, 16'h0002, 16'h2222, 16'h0002, 1, 0); // 23
        add(0, 1, 1, 0, 16'h0000, 16'h3333, 16'h0002, 16'h2222, 16'h0002, 1, 0); // 24 stall
        add(1, 1, 1, 0, 16'h0000, 16'h3333, 16'h0000, 16'h0000, 16'h0000, 0, 0); // 25 reset in stall
        add(0, 0, 1, 0, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 0, 0); // 26 FILL bubble
        add(0, 0, 1, 0, 16'h0000, 16'h1234, 16'h0002, 16'h1234, 16'h0002, 1, 0); // 27
        add(0, 0, 1, 1, 16'h0020, 16'h0000, 16'h0020, 16'h0000, 16'h0002, 0, 0); // 28
        add(0, 0, 1, 0, 16'h0000, 16'hF0AA, 16'h0020, 16'hF0AA, 16'h0022, 1, 1); // 29 halted
        add(1, 0, 1, 0, 16'h0000, 16'hF0AA, 16'h0000, 16'h0000, 16'h0000, 0, 0); // 30 reset in HALTED
        add(0, 0, 1, 0, 16'h0000, 16'hF000, 16'h0000, 16'h0000, 16'h0000, 0, 0); // 31 FILL ignores word
        add(0, 0, 1, 0, 16'h0000, 16'h1234, 16'h0002, 16'h1234, 16'h0002, 1, 0); // 32
        add(1, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0); // 33 reset
        add(0, 0, 1, 1, 16'h0030, 16'h9999, 16'h0030, 16'h0000, 16'h0000, 0, 0); // 34 branch in FILL
        add(0, 0, 1, 0, 16'h0000, 16'h9999, 16'h0032, 16'h9999, 16'h0032, 1, 0); // 35

        rst = 1'b1; halt = 1'b0; pc_enable = 1'b0; branch_taken = 1'b0;
        branch_target = '0; imem_data = '0;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t e;
            rst           = vecs[i].rst;
            halt          = vecs[i].halt;
            pc_enable     = vecs[i].pe;
            branch_taken  = vecs[i].br;
            branch_target = vecs[i].tgt;
            imem_data     = vecs[i].imem;
            sb.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check("pc_IF",          i, pc_IF,          e.pc);
            check("imem_addr",      i, imem_addr,      e.pc);
            check("instruction_ID", i, instruction_ID, e.instr);
            check("pc_plus2_ID",    i, pc_plus2_ID,    e.pp2);
            check("valid_ID",       i, {15'b0, valid_ID}, {15'b0, e.v});
            check("halted",         i, {15'b0, halted},   {15'b0, e.h});
        end

        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
